// File: rtl/systolic_pkg.sv
// Shared types, defaults and the saturating fixed-point MAC used by the
// weight-stationary systolic array.
package systolic_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_FRAC_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam logic signed [DEF_DATA_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [DEF_DATA_W-1:0] SAT_MIN = 16'sh8000;

    // Full-precision product, floor shift, add, clamp to a data_w-bit signed
    // range. Operands arrive sign-extended to 32 bits so data_w may be <= 32.
    function automatic logic signed [63:0] sat_mac(
        input logic signed [31:0] a,
        input logic signed [31:0] w,
        input logic signed [31:0] psum,
        input int                 data_w,
        input int                 frac_w
    );
        logic signed [63:0] prod;
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        prod = 64'(a) * 64'(w);
        sum  = (prod >>> frac_w) + 64'(psum);
        hi   = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo   = -(64'sd1 <<< (data_w - 1));
        if (sum > hi) begin
            return hi;
        end else if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/systolic_array_param_pe.sv
// One processing element: stationary weight, registered input pass-through
// and a registered saturating partial sum that only advance on valid slots.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_load,
    input  logic signed [DATA_W-1:0] w_in,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic                     v_in,
    input  logic signed [DATA_W-1:0] psum_in,
    output logic signed [DATA_W-1:0] a_out,
    output logic                     v_out,
    output logic signed [DATA_W-1:0] psum_out
);

    logic signed [DATA_W-1:0] w_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q      <= '0;
            a_out    <= '0;
            v_out    <= 1'b0;
            psum_out <= '0;
        end else begin
            if (w_load) begin
                w_q <= w_in;
            end
            v_out <= v_in;
            if (v_in) begin
                a_out    <= a_in;
                psum_out <= DATA_W'(sat_mac(32'(a_in), 32'(w_q), 32'(psum_in), DATA_W, FRAC_W));
            end
        end
    end

endmodule

// File: rtl/systolic_array_param.sv
// Parametrised weight-stationary ROWS x COLS systolic array with internal
// input skew, output de-skew, row-serial weight load and a control FSM.
module systolic_array_param
    import systolic_pkg::*;
#(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   w_valid,
    output logic                   w_ready,
    input  logic [COLS*DATA_W-1:0] w_row,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ROWS*DATA_W-1:0] in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    output logic [COLS*DATA_W-1:0] out_data,
    output logic                   out_last,
    output logic                   done,
    output logic                   busy
);

    localparam int L  = ROWS + COLS;
    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

    state_t        state;
    logic [CW-1:0] row_cnt;
    logic          w_acc;
    logic          in_acc;
    logic [L-1:0]  vld_p;
    logic [L-1:0]  lst_p;

    // The weight port wins over the input port while idle.
    assign w_ready  = (state == IDLE) || (state == LOAD);
    assign in_ready = ((state == IDLE) && !w_valid) || (state == STREAM);
    assign busy     = (state != IDLE);
    assign w_acc    = w_valid && w_ready;
    assign in_acc   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            row_cnt <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (w_acc) begin
                        row_cnt <= CW'(1);
                        state   <= LOAD;
                    end else if (in_acc) begin
                        state <= in_last ? DRAIN : STREAM;
                    end
                end
                LOAD: begin
                    if (w_acc) begin
                        if (row_cnt == LAST_ROW) begin
                            row_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (in_acc && in_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_valid && out_last) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Beat tags travel alongside the datapath for the full latency L.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
            lst_p <= '0;
        end else begin
            vld_p <= {vld_p[L-2:0], in_acc};
            lst_p <= {lst_p[L-2:0], in_acc && in_last};
        end
    end

    assign out_valid = vld_p[L-1];
    assign out_last  = lst_p[L-1];

    // Stage p0: input skew, row r delayed r cycles, invalid slots zero-filled.
    logic signed [DATA_W-1:0] a_sk [ROWS];
    logic                     v_sk [ROWS];

    for (genvar r = 0; r < ROWS; r++) begin : g_skew
        if (r == 0) begin : g_direct
            assign a_sk[0] = in_acc ? in_data[DATA_W-1:0] : '0;
            assign v_sk[0] = in_acc;
        end else begin : g_delay
            logic signed [DATA_W-1:0] sk_p0 [r];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < r; k++) begin
                        sk_p0[k] <= '0;
                    end
                end else begin
                    sk_p0[0] <= in_acc ? in_data[r*DATA_W +: DATA_W] : '0;
                    for (int k = 1; k < r; k++) begin
                        sk_p0[k] <= sk_p0[k-1];
                    end
                end
            end
            assign a_sk[r] = sk_p0[r-1];
            assign v_sk[r] = vld_p[r-1];
        end
    end

    // Stage p1: PE grid, inputs flow right and partial sums flow down.
    logic signed [DATA_W-1:0] a_h [ROWS][COLS];
    logic                     v_h [ROWS][COLS];
    logic signed [DATA_W-1:0] p_v [ROWS][COLS];

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic signed [DATA_W-1:0] a_i;
            logic signed [DATA_W-1:0] p_i;
            logic                     v_i;

            if (c == 0) begin : g_left
                assign a_i = a_sk[r];
                assign v_i = v_sk[r];
            end else begin : g_inner
                assign a_i = a_h[r][c-1];
                assign v_i = v_h[r][c-1];
            end

            if (r == 0) begin : g_top
                assign p_i = '0;
            end else begin : g_below
                assign p_i = p_v[r-1][c];
            end

            systolic_pe #(
                .DATA_W(DATA_W),
                .FRAC_W(FRAC_W)
            ) u_pe (
                .clk     (clk),
                .rst     (rst),
                .w_load  (w_acc && (row_cnt == CW'(r))),
                .w_in    (w_row[c*DATA_W +: DATA_W]),
                .a_in    (a_i),
                .v_in    (v_i),
                .psum_in (p_i),
                .a_out   (a_h[r][c]),
                .v_out   (v_h[r][c]),
                .psum_out(p_v[r][c])
            );
        end
    end

    // Stage p2: de-skew, column c delayed COLS-1-c cycles, then output register.
    logic signed [DATA_W-1:0] col_p2 [COLS];

    for (genvar c = 0; c < COLS; c++) begin : g_deskew
        localparam int D = COLS - 1 - c;
        if (D == 0) begin : g_pass
            assign col_p2[c] = p_v[ROWS-1][c];
        end else begin : g_delay
            logic signed [DATA_W-1:0] ds_p2 [D];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < D; k++) begin
                        ds_p2[k] <= '0;
                    end
                end else begin
                    ds_p2[0] <= p_v[ROWS-1][c];
                    for (int k = 1; k < D; k++) begin
                        ds_p2[k] <= ds_p2[k-1];
                    end
                end
            end
            assign col_p2[c] = ds_p2[D-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
        end else begin
            for (int c = 0; c < COLS; c++) begin
                out_data[c*DATA_W +: DATA_W] <= col_p2[c];
            end
        end
    end

endmodule

// File: tb/tb_systolic_array_param.sv
// Bench for systolic_array_param at default parameters: vector table plus
// hand sequences, all checked through an output scoreboard.
module tb_systolic_array_param;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 16;
    localparam int L    = ROWS + COLS;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 w_valid;
    logic                 w_ready;
    logic [COLS*DW-1:0]   w_row;
    logic                 in_valid;
    logic                 in_ready;
    logic [ROWS*DW-1:0]   in_data;
    logic                 in_last;
    logic                 out_valid;
    logic [COLS*DW-1:0]   out_data;
    logic                 out_last;
    logic                 done;
    logic                 busy;

    systolic_array_param #(
        .ROWS(ROWS), .COLS(COLS), .DATA_W(DW), .FRAC_W(8)
    ) dut (
        .clk(clk), .rst(rst),
        .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    int cmp_n = 0;
    int bad_n = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] d;
        logic        l;
        int          c;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [15:0] wd;
        logic [15:0] wo;
        logic [63:0] v;
        logic [63:0] e;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        cmp_n++;
        if (act !== exp) begin
            bad_n++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Output monitor: scoreboard pop, latency and done-pulse checks.
    logic prev_last = 1'b0;
    always @(negedge clk) begin : mon
        sb_t e;
        if (rst) begin
            prev_last = 1'b0;
        end else begin
            if (prev_last || done) check("done_pulse", {63'b0, done}, {63'b0, prev_last});
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    check("stray_out_valid", {63'b0, out_valid}, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_last", {63'b0, out_last}, {63'b0, e.l});
                    check("latency", 64'(cyc - e.c), 64'(L));
                end
            end
            prev_last = out_valid && out_last;
        end
    end

    task automatic idle_inputs();
        @(negedge clk);
        w_valid  = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic load_w(input logic [15:0] wd, input logic [15:0] wo);
        for (int r = 0; r < ROWS; r++) begin
            @(negedge clk);
            w_valid = 1'b1;
            for (int c = 0; c < COLS; c++) w_row[c*DW +: DW] = (r == c) ? wd : wo;
            #1;
            check("w_ready", {63'b0, w_ready}, 64'd1);
        end
        idle_inputs();
    endtask

    task automatic send(input logic [63:0] v, input logic last, input logic [63:0] e);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = v;
        in_last  = last;
        #1;
        check("in_ready", {63'b0, in_ready}, 64'd1);
        if (in_ready) sbq.push_back('{d: e, l: last, c: cyc});
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        idle_inputs();
        check("busy_drain", {63'b0, busy}, 64'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", {63'b0, seen}, 64'd1);
        check("sb_drained", 64'(sbq.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        w_valid  = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int nv;
        rst = 1'b1; w_valid = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        w_row = '0; in_data = '0;

        tbl[0] = '{16'h0080, 16'h0080, 64'h0100_0100_0100_0100, 64'h0200_0200_0200_0200};
        tbl[1] = '{16'h7F00, 16'h7F00, 64'h7F00_7F00_7F00_7F00, 64'h7FFF_7FFF_7FFF_7FFF};
        tbl[2] = '{16'h7F00, 16'h7F00, 64'h8100_8100_8100_8100, 64'h8000_8000_8000_8000};
        tbl[3] = '{16'h0200, 16'h0100, 64'h0040_0080_FF00_0100, 64'h0100_0140_FFC0_01C0};
        tbl[4] = '{16'h0001, 16'h0001, 64'h0080_0080_0080_0080, 64'h0000_0000_0000_0000};
        tbl[5] = '{16'h0001, 16'h0001, 64'hFF80_FF80_FF80_FF80, 64'hFFFC_FFFC_FFFC_FFFC};

        repeat (2) @(negedge clk);
        check("rst_w_ready",   {63'b0, w_ready},   64'd1);
        check("rst_in_ready",  {63'b0, in_ready},  64'd1);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_out_last",  {63'b0, out_last},  64'd0);
        check("rst_done",      {63'b0, done},      64'd0);
        check("rst_busy",      {63'b0, busy},      64'd0);
        check("rst_out_data",  out_data,           64'd0);
        rst = 1'b0;

        // Identity weights.
        load_w(16'h0100, 16'h0000);
        send(64'h0400_0300_0200_0100, 1'b1, 64'h0400_0300_0200_0100);
        wait_done();

        for (int i = 0; i < 6; i++) begin
            load_w(tbl[i].wd, tbl[i].wo);
            send(tbl[i].v, 1'b1, tbl[i].e);
            wait_done();
        end

        // Three back-to-back beats must emerge on consecutive cycles.
        load_w(16'h0080, 16'h0080);
        send(64'h0100_0100_0100_0100, 1'b0, 64'h0200_0200_0200_0200);
        send(64'h0100_0100_0100_0100, 1'b0, 64'h0200_0200_0200_0200);
        send(64'h0100_0100_0100_0100, 1'b1, 64'h0200_0200_0200_0200);
        wait_done();

        // Weight and input offered together; input must wait out the load.
        for (int r = 0; r < ROWS; r++) begin
            @(negedge clk);
            w_valid  = 1'b1;
            for (int c = 0; c < COLS; c++) w_row[c*DW +: DW] = (r == c) ? 16'h0200 : 16'h0000;
            in_valid = 1'b1;
            in_data  = 64'h0400_0300_0200_0100;
            in_last  = 1'b1;
            #1;
            check("contend_in_ready", {63'b0, in_ready}, 64'd0);
            check("contend_w_ready",  {63'b0, w_ready},  64'd1);
        end
        @(negedge clk);
        w_valid = 1'b0;
        #1;
        check("after_load_in_ready", {63'b0, in_ready}, 64'd1);
        if (in_ready) sbq.push_back('{d: 64'h0800_0600_0400_0200, l: 1'b1, c: cyc});
        wait_done();

        // Bubbles: A, two idle slots, B with last.
        send(64'h0001_0002_0003_0004, 1'b0, 64'h0002_0004_0006_0008);
        idle_inputs();
        idle_inputs();
        send(64'h0010_0020_0030_0040, 1'b1, 64'h0020_0040_0060_0080);
        wait_done();

        // Reset while two beats are in flight.
        load_w(16'h0080, 16'h0080);
        send(64'h0100_0100_0100_0100, 1'b0, 64'h0200_0200_0200_0200);
        send(64'h0100_0100_0100_0100, 1'b0, 64'h0200_0200_0200_0200);
        idle_inputs();
        repeat (2) @(negedge clk);
        do_reset();
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        check("post_rst_valid_cnt", 64'(nv), 64'd0);
        check("post_rst_busy",      {63'b0, busy},    64'd0);
        check("post_rst_w_ready",   {63'b0, w_ready}, 64'd1);
        check("post_rst_out_data",  out_data,         64'd0);
        send(64'h0100_0100_0100_0100, 1'b1, 64'h0000_0000_0000_0000);
        wait_done();

        repeat (3) @(negedge clk);
        check("sb_final_empty", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
        $finish;
    end

endmodule

// File: doc/systolic_array_param.md
Name: systolic_array_param

Overview:
- Parametrised weight-stationary ROWS x COLS systolic array. Successor to the fixed 3x3 array.
- Adds an internal input skew and output de-skew, so input and output vectors are aligned and leave the block with no external staggering needed.
- Adds row-serial weight loading, valid/ready streaming with a last tag, a control FSM, a done pulse and saturating signed fixed-point MACs.
- Sits between the unified input buffer and the bias/activation stage.

Parameters:
- ROWS, 4, number of PE rows (input vector length, K dimension); >=2
- COLS, 4, number of PE columns (output vector length, N dimension); >=2
- DATA_W, 16, signed fixed-point word width
- FRAC_W, 8, fractional bits (default Q8.8)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- w_valid  in  1  weight row present on w_row
- w_ready  out  1  block accepts a weight row
- w_row  in  COLS*DATA_W  one weight row; column c at bits [c*DATA_W +: DATA_W]
- in_valid  in  1  input vector present
- in_ready  out  1  block accepts an input vector
- in_data  in  ROWS*DATA_W  input vector; element r drives array row r
- in_last  in  1  marks the final vector of a batch
- out_valid  out  1  out_data holds one aligned result vector
- out_data  out  COLS*DATA_W  result vector; column c = sum over r of in[r]*W[r][c]
- out_last  out  1  out_valid beat corresponds to an in_last beat
- done  out  1  single-cycle pulse after the out_last beat
- busy  out  1  FSM is not IDLE

Behaviour:
- Reset (synchronous, rst high at posedge):
  - FSM goes to IDLE.
  - All PE weights, psums, skew and de-skew registers, and valid/last tag pipes are cleared to 0.
  - w_ready=1, in_ready=1, out_valid=0, out_last=0, done=0, busy=0, out_data=0.
  - Reset mid-stream or mid-load discards all in-flight data. No out_valid follows the reset.
- FSM states: IDLE, LOAD, STREAM, DRAIN.
- IDLE:
  - w_ready=in_ready=1.
  - An accepted w_valid beat goes to LOAD and writes row 0.
  - An accepted in_valid beat goes to STREAM.
  - If w_valid and in_valid are high in the same cycle, the weight wins: in_ready=0 that cycle.
- LOAD:
  - w_ready=1, in_ready=0.
  - Rows are written top-down through a row counter, one per accepted beat. Gaps are allowed.
  - After the ROWS-th row, return to IDLE.
  - Weights persist until rewritten or reset.
  - Streaming with a partially loaded weight set is impossible by construction.
- STREAM:
  - in_ready=1, w_ready=0.
  - Each accepted beat enters the skew stage. Bubbles (in_valid=0) propagate as invalid slots.
  - Accepting in_last goes to DRAIN.
- DRAIN:
  - in_ready=0, w_ready=0.
  - Wait until the tagged last beat emerges (out_last=1), then assert done for 1 cycle and return to IDLE.
  - done coincides with the cycle after out_last.
- Datapath timing:
  - Element r is delayed r cycles by the skew stage.
  - Inputs move right one PE per cycle; psums move down one PE per cycle, registered.
  - Column c is delayed COLS-1-c cycles by the de-skew stage.
- Latency: fixed L = ROWS+COLS cycles from the accepted in beat to the matching out_valid.
  - Throughput is 1 vector/cycle.
  - A valid/last tag shift register of depth L tracks the beats.
- No output backpressure: the consumer must always accept out_valid beats.
- Arithmetic per PE:
  - Form the full 2*DATA_W signed product.
  - Arithmetic shift right by FRAC_W (floor).
  - Add psum_in, sign-extended.
  - Saturate to the signed DATA_W range: max 0x7FFF, min 0x8000 at defaults.
  - The top row's psum_in = 0.
- PEs hold their accumulation only through registers. A PE holds its psum/input regs when its slot is invalid. Invalid slots are zero-filled at the skew input.

Decomposition:
- Package systolic_pkg holds:
  - DATA_W and FRAC_W defaults
  - the typedef state_t {IDLE, LOAD, STREAM, DRAIN}
  - SAT_MAX and SAT_MIN constants
  - function sat_mac(a, w, psum)
- One sub-module, systolic_pe: weight register, input pass-through register, psum register using sat_mac, and a load-enable input.
- The array is generated with nested generate loops. Skew and de-skew are generate-built shift registers in the top module.

Test Plan:
- Identity test (defaults):
  - Load W=I, with 1.0=0x0100 on the diagonal.
  - Stream in=[0x0100,0x0200,0x0300,0x0400] with last.
  - Expect exactly 8 cycles later out=[0x0100,0x0200,0x0300,0x0400], out_last=1, then done 1 cycle later.
- Dense product:
  - Load all weights 0x0080 (0.5). Stream 3 back-to-back vectors of all 0x0100.
  - Expect 3 consecutive out beats of all 0x0200 and no gaps.
- Saturation:
  - Load all weights 0x7F00. Stream in all 0x7F00.
  - Expect every column = 0x7FFF. With negated inputs, expect 0x8000.
- Contention and backpressure:
  - Raise w_valid and in_valid together in IDLE: expect in_ready=0 and the row accepted as row 0.
  - Raise in_valid during LOAD: expect in_ready=0 until all 4 rows are loaded.
- Bubbles:
  - Stream A, idle 2 cycles, then B(last).
  - Expect out_valid pattern 1,0,0,1 at the correct latency and out_last only on B.
- Mid-stream reset:
  - Assert rst 3 cycles after 2 beats are accepted.
  - Expect no out_valid afterwards, all outputs at reset values, and a reload required (weights are 0).
